// File: rtl/fnn_pkg.sv
// Shared constants for the FNN layer sequencer: state encodings, default
// geometry and the datapath operand-select encodings.
package fnn_pkg;

    localparam int FNN_N_SAMPLES = 750;
    localparam int FNN_N_LAYERS  = 3;
    localparam int FNN_ADDR_W    = 10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LAYER    = 3'd2,
        S_CLASSIFY = 3'd3,
        S_DONE     = 3'd4
    } fnn_state_e;

    // Plain-vector aliases so the state register stays a simple logic flop.
    localparam logic [2:0] ST_IDLE     = S_IDLE;
    localparam logic [2:0] ST_FETCH    = S_FETCH;
    localparam logic [2:0] ST_LAYER    = S_LAYER;
    localparam logic [2:0] ST_CLASSIFY = S_CLASSIFY;
    localparam logic [2:0] ST_DONE     = S_DONE;

    localparam logic SRC_INPUT = 1'b0;
    localparam logic SRC_PREV  = 1'b1;

endpackage

// File: rtl/fnn_acc_counter.sv
// Saturating counter of correct predictions; clr wins over inc and the
// count sticks at all-ones instead of wrapping.
module fnn_acc_counter
    import fnn_pkg::*;
#(
    parameter int W = FNN_ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fnn_layer_sequencer.sv
// Control FSM stepping samples through fetch, per-layer evaluation and
// classification. Accuracy counting is built only with FNN_ACC_COUNT_EN.
module fnn_layer_sequencer
    import fnn_pkg::*;
#(
    parameter int N_SAMPLES = FNN_N_SAMPLES,
    parameter int N_LAYERS  = FNN_N_LAYERS,
    parameter int ADDR_W    = FNN_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mem_ack,
    input  logic                eq,
    output logic                mem_rd,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                ld_inp,
    output logic [1:0]          sel_layer,
    output logic [N_LAYERS-1:0] ld_layer,
    output logic                sel_src,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   correct_cnt,
    output logic [2:0]          state_dbg
);

    localparam logic [1:0]        LAST_LAYER  = 2'(N_LAYERS - 1);
    localparam logic [ADDR_W-1:0] LAST_SAMPLE = ADDR_W'(N_SAMPLES - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] sample_idx_q, sample_idx_d;
    logic [1:0]        layer_idx_q, layer_idx_d;

    // Memory handshake: mem_rd stays high for the whole FETCH state and the
    // transfer completes in the cycle mem_ack is seen high, which is also the
    // cycle ld_inp captures the data. mem_ack in any other state is ignored.
    always_comb begin
        state_d      = state_q;
        sample_idx_d = sample_idx_q;
        layer_idx_d  = layer_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_FETCH;
                    sample_idx_d = '0;
                    layer_idx_d  = '0;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    state_d     = ST_LAYER;
                    layer_idx_d = '0;
                end
            end
            ST_LAYER: begin
                if (layer_idx_q == LAST_LAYER) begin
                    state_d     = ST_CLASSIFY;
                    layer_idx_d = '0;
                end else begin
                    layer_idx_d = layer_idx_q + 2'd1;
                end
            end
            ST_CLASSIFY: begin
                if (sample_idx_q == LAST_SAMPLE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d      = ST_FETCH;
                    sample_idx_d = sample_idx_q + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sample_idx_q <= '0;
            layer_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            sample_idx_q <= sample_idx_d;
            layer_idx_q  <= layer_idx_d;
        end
    end

    always_comb begin
        mem_rd    = (state_q == ST_FETCH);
        ld_inp    = (state_q == ST_FETCH) && mem_ack;
        sel_layer = (state_q == ST_LAYER) ? layer_idx_q : 2'd0;
        sel_src   = ((state_q == ST_LAYER) && (layer_idx_q != 2'd0)) ? SRC_PREV : SRC_INPUT;
        busy      = (state_q == ST_FETCH) || (state_q == ST_LAYER) || (state_q == ST_CLASSIFY);
        done      = (state_q == ST_DONE);
        ld_layer  = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            ld_layer[i] = (state_q == ST_LAYER) && (layer_idx_q == 2'(i));
        end
    end

    assign mem_addr  = sample_idx_q;
    assign state_dbg = state_q;

`ifdef FNN_ACC_COUNT_EN
    logic acc_clr;
    logic acc_inc;

    assign acc_clr = (state_q == ST_IDLE) && start;
    assign acc_inc = (state_q == ST_CLASSIFY) && eq;

    fnn_acc_counter #(
        .W(ADDR_W)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (acc_clr),
        .inc   (acc_inc),
        .count (correct_cnt)
    );
`else
    logic eq_unused;

    assign eq_unused   = eq;
    assign correct_cnt = '0;
`endif

endmodule
